// File: rtl/cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// cache_fill_arbiter
//
// Miss controller that shares one main-memory read port between the I-cache
// and the D-cache. When a miss is seen in IDLE it picks a side (D wins ties,
// because the D-side instruction is older), issues WORDS back-to-back reads
// for the aligned block, streams each returned word into the selected cache
// data array, and pulses that cache's tag/valid write once the last word has
// landed. Only one fill is ever outstanding.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   imiss/imiss_addr I-cache miss request and byte address (held until done)
//   dmiss/dmiss_addr D-cache miss request and byte address (held until done)
//   mem_rd_en        one read issued to memory this cycle
//   mem_addr         byte address of that read
//   mem_data_valid   memory returns a word this cycle (in issue order)
//   mem_data         the returned word
//   fill_data        word to write into the cache (mem_data while writing)
//   fill_word        word index within the block being written
//   fill_we_i/_d     data-array write enable for the I / D cache
//   fill_done_i/_d   one-cycle tag/valid write pulse for the I / D cache
//   stall_inst_miss  freezes PC and IF/ID
//   stall_data_miss  freezes the whole pipeline
//   busy             controller is not idle
// ---------------------------------------------------------------------------
module cache_fill_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     imiss,
    input  logic [ADDR_W-1:0]        imiss_addr,
    input  logic                     dmiss,
    input  logic [ADDR_W-1:0]        dmiss_addr,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_data_valid,
    input  logic [DATA_W-1:0]        mem_data,
    output logic [DATA_W-1:0]        fill_data,
    output logic [$clog2(WORDS)-1:0] fill_word,
    output logic                     fill_we_i,
    output logic                     fill_we_d,
    output logic                     fill_done_i,
    output logic                     fill_done_d,
    output logic                     stall_inst_miss,
    output logic                     stall_data_miss,
    output logic                     busy
);

    localparam int LOGW = $clog2(WORDS);
    localparam int CW   = LOGW + 1;

    // Words are two bytes wide, so a block spans 2*WORDS bytes; clearing
    // these low address bits gives the block base.
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL_D = 3'd1,
        FILL_I = 3'd2,
        DONE_D = 3'd3,
        DONE_I = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] base_next;
    logic [CW-1:0]     iss;
    logic [CW-1:0]     iss_next;
    logic [CW-1:0]     rcv;
    logic [CW-1:0]     rcv_next;
    logic              in_fill;

    // The controller counts returned words rather than elapsed time, so the
    // memory latency never enters the logic.
    logic unused_mem_lat;
    assign unused_mem_lat = (MEM_LAT != 0);

    // State, block base and the issue/receive counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
            iss   <= '0;
            rcv   <= '0;
        end else begin
            state <= state_next;
            base  <= base_next;
            iss   <= iss_next;
            rcv   <= rcv_next;
        end
    end

    assign in_fill = (state == FILL_D) || (state == FILL_I);

    // Next-state and output decode. The issue side and the receive side run
    // independently inside a fill: reads go out every cycle until WORDS have
    // been issued, while returned words are written the cycle they arrive.
    always_comb begin
        state_next  = state;
        base_next   = base;
        iss_next    = iss;
        rcv_next    = rcv;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        fill_data   = '0;
        fill_word   = '0;
        fill_we_i   = 1'b0;
        fill_we_d   = 1'b0;
        fill_done_i = 1'b0;
        fill_done_d = 1'b0;

        case (state)
            IDLE: begin
                if (dmiss) begin
                    state_next = FILL_D;
                    base_next  = dmiss_addr & ~OFF_MASK;
                    iss_next   = '0;
                    rcv_next   = '0;
                end else if (imiss) begin
                    state_next = FILL_I;
                    base_next  = imiss_addr & ~OFF_MASK;
                    iss_next   = '0;
                    rcv_next   = '0;
                end
            end

            FILL_D, FILL_I: begin
                if (iss < CW'(WORDS)) begin
                    mem_rd_en = 1'b1;
                    // Offset lives entirely in the cleared low bits, so the
                    // sum never carries out of the block.
                    mem_addr  = base + {{(ADDR_W - LOGW - 1){1'b0}}, iss[LOGW-1:0], 1'b0};
                    iss_next  = iss + CW'(1);
                end
                if (mem_data_valid && (rcv < CW'(WORDS))) begin
                    fill_data = mem_data;
                    fill_word = rcv[LOGW-1:0];
                    if (state == FILL_D) begin
                        fill_we_d = 1'b1;
                    end else begin
                        fill_we_i = 1'b1;
                    end
                    rcv_next = rcv + CW'(1);
                    if (rcv == CW'(WORDS - 1)) begin
                        state_next = (state == FILL_D) ? DONE_D : DONE_I;
                    end
                end
            end

            DONE_D: begin
                fill_done_d = 1'b1;
                state_next  = IDLE;
            end

            DONE_I: begin
                fill_done_i = 1'b1;
                state_next  = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stalls follow the raw miss lines so the pipeline freezes in the very
    // cycle a miss appears, and stay up through the DONE cycle of that side.
    assign stall_data_miss = dmiss | (state == FILL_D) | (state == DONE_D);
    assign stall_inst_miss = imiss | (state == FILL_I) | (state == DONE_I);
    assign busy            = (state != IDLE);

    logic unused_in_fill;
    assign unused_in_fill = in_fill;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_arbiter
//
// Directed bench for cache_fill_arbiter. A 4-cycle-latency memory model
// answers every read with (address ^ 0xA5A5). Stimulus pushes the expected
// reads, cache writes and done pulses (with their cycle numbers) into
// queues; a monitor on the falling edge pops and compares whenever the DUT
// presents one of those events. Stalls, busy and idle quietness are checked
// directly from the stimulus thread.
// ---------------------------------------------------------------------------
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imiss;
    logic [15:0] imiss_addr;
    logic        dmiss;
    logic [15:0] dmiss_addr;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i;
    logic        fill_we_d;
    logic        fill_done_i;
    logic        fill_done_d;
    logic        stall_inst_miss;
    logic        stall_data_miss;
    logic        busy;

    logic        manual_valid;
    logic [15:0] manual_data;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int t0;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } rd_t;

    typedef struct {
        int          cyc;
        logic        side;
        logic [2:0]  word;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int   cyc;
        logic side;
    } dn_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    dn_t dn_q[$];

    cache_fill_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .WORDS  (8),
        .MEM_LAT(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imiss          (imiss),
        .imiss_addr     (imiss_addr),
        .dmiss          (dmiss),
        .dmiss_addr     (dmiss_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .fill_we_i      (fill_we_i),
        .fill_we_d      (fill_we_d),
        .fill_done_i    (fill_done_i),
        .fill_done_d    (fill_done_d),
        .stall_inst_miss(stall_inst_miss),
        .stall_data_miss(stall_data_miss),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: a read issued in cycle k returns in cycle k+4.
    logic [3:0]  pipe_v = 4'b0000;
    logic [15:0] pipe_a [4];

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[2:0], mem_rd_en};
        pipe_a[0] <= mem_addr;
        pipe_a[1] <= pipe_a[0];
        pipe_a[2] <= pipe_a[1];
        pipe_a[3] <= pipe_a[2];
    end

    assign mem_data_valid = pipe_v[3] | manual_valid;
    assign mem_data       = pipe_v[3] ? (pipe_a[3] ^ 16'hA5A5) : manual_data;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic im, input logic [15:0] ia,
                                 input logic dm, input logic [15:0] da,
                                 input logic r, input logic mv);
        imiss        = im;
        imiss_addr   = ia;
        dmiss        = dm;
        dmiss_addr   = da;
        rst          = r;
        manual_valid = mv;
    endtask

    // Queue the events of one fill whose first read goes out in cycle t_rd.
    task automatic expectFill(input int t_rd, input logic side,
                              input logic [15:0] base, input int n_rd,
                              input int n_wr, input bit done);
        logic [15:0] a;
        for (int i = 0; i < n_rd; i++) begin
            a = base + 16'(2 * i);
            rd_q.push_back('{cyc: t_rd + i, addr: a});
        end
        for (int i = 0; i < n_wr; i++) begin
            a = base + 16'(2 * i);
            wr_q.push_back('{cyc: t_rd + 4 + i, side: side, word: 3'(i),
                             data: a ^ 16'hA5A5});
        end
        if (done) dn_q.push_back('{cyc: t_rd + 12, side: side});
    endtask

    // Advance n cycles with inputs unchanged, checking both stalls each cycle.
    task automatic holdCycles(input int n, input logic esi, input logic esd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("stall_inst_miss", 32'(stall_inst_miss), 32'(esi));
            checkOutput("stall_data_miss", 32'(stall_data_miss), 32'(esd));
            @(posedge clk);
            #1;
        end
    endtask

    // Advance n cycles expecting every output at zero.
    task automatic idleCheck(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("idle_mem_rd_en",   32'(mem_rd_en),       32'd0);
            checkOutput("idle_mem_addr",    32'(mem_addr),        32'd0);
            checkOutput("idle_fill_data",   32'(fill_data),       32'd0);
            checkOutput("idle_fill_word",   32'(fill_word),       32'd0);
            checkOutput("idle_fill_we_i",   32'(fill_we_i),       32'd0);
            checkOutput("idle_fill_we_d",   32'(fill_we_d),       32'd0);
            checkOutput("idle_fill_done_i", 32'(fill_done_i),     32'd0);
            checkOutput("idle_fill_done_d", 32'(fill_done_d),     32'd0);
            checkOutput("idle_stall_inst",  32'(stall_inst_miss), 32'd0);
            checkOutput("idle_stall_data",  32'(stall_data_miss), 32'd0);
            checkOutput("idle_busy",        32'(busy),            32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monRead();
        rd_t e;
        checkOutput("read_expected", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            checkOutput("read_cycle", 32'(cyc), 32'(e.cyc));
            checkOutput("read_addr", 32'(mem_addr), 32'(e.addr));
        end
    endtask

    task automatic monWrite(input logic side);
        wr_t e;
        checkOutput("write_expected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            checkOutput("write_side", 32'(side), 32'(e.side));
            checkOutput("write_cycle", 32'(cyc), 32'(e.cyc));
            checkOutput("fill_word", 32'(fill_word), 32'(e.word));
            checkOutput("fill_data", 32'(fill_data), 32'(e.data));
        end
    endtask

    task automatic monDone(input logic side);
        dn_t e;
        checkOutput("done_expected", 32'(dn_q.size() > 0), 32'd1);
        if (dn_q.size() > 0) begin
            e = dn_q.pop_front();
            checkOutput("done_side", 32'(side), 32'(e.side));
            checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Monitor: compares every DUT event against the head of its queue.
    always @(negedge clk) begin
        if (mem_rd_en)   monRead();
        if (fill_we_i)   monWrite(1'b0);
        if (fill_we_d)   monWrite(1'b1);
        if (fill_done_i) monDone(1'b0);
        if (fill_done_d) monDone(1'b1);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        manual_data = 16'hBEEF;
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        idleCheck(1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        idleCheck(2);

        // Plain D miss at 0x1236.
        $display("[TB] test 1: D miss 0x1236");
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h1236, 1'b0, 1'b0);
        t0 = cyc;
        expectFill(t0 + 1, 1'b1, 16'h1230, 8, 8, 1'b1);
        holdCycles(14, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        idleCheck(2);

        // Simultaneous misses: D first, then I.
        $display("[TB] test 2: simultaneous I 0x0040 / D 0x8008");
        applyStimulus(1'b1, 16'h0040, 1'b1, 16'h8008, 1'b0, 1'b0);
        t0 = cyc;
        expectFill(t0 + 1, 1'b1, 16'h8000, 8, 8, 1'b1);
        expectFill(t0 + 15, 1'b0, 16'h0040, 8, 8, 1'b1);
        holdCycles(14, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b0);
        holdCycles(14, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        idleCheck(2);

        // I fill in progress, D miss arrives in cycle 3.
        $display("[TB] test 3: I miss 0x2468, D miss 0x300C mid-fill");
        applyStimulus(1'b1, 16'h2468, 1'b0, 16'h0000, 1'b0, 1'b0);
        t0 = cyc;
        expectFill(t0 + 1, 1'b0, 16'h2460, 8, 8, 1'b1);
        expectFill(t0 + 15, 1'b1, 16'h3000, 8, 8, 1'b1);
        holdCycles(3, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h2468, 1'b1, 16'h300C, 1'b0, 1'b0);
        holdCycles(11, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h300C, 1'b0, 1'b0);
        holdCycles(14, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        idleCheck(2);

        // Top-of-memory block must not wrap.
        $display("[TB] test 4: D miss 0xFFFE");
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        t0 = cyc;
        expectFill(t0 + 1, 1'b1, 16'hFFF0, 8, 8, 1'b1);
        holdCycles(14, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        idleCheck(2);

        // Reset in cycle 7 of a D fill: reads 1-7, writes 5-7, no done.
        $display("[TB] test 5: reset mid D fill");
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h4002, 1'b0, 1'b0);
        t0 = cyc;
        expectFill(t0 + 1, 1'b1, 16'h4000, 7, 3, 1'b0);
        holdCycles(7, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        holdCycles(1, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        idleCheck(6);

        // Stray memory beats while idle.
        $display("[TB] test 6: mem_data_valid toggling in IDLE");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, (i % 2) == 0);
            idleCheck(1);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        idleCheck(2);

        checkOutput("reads_left", 32'(rd_q.size()), 32'd0);
        checkOutput("writes_left", 32'(wr_q.size()), 32'd0);
        checkOutput("dones_left", 32'(dn_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Miss controller that shares the single 4-cycle-latency main memory between the I-cache and the D-cache.
- Arbitrates between simultaneous misses and sequences an 8-word block fill for the chosen cache.
- Writes each returned word into that cache and pulses its tag/valid update when the fill completes.
- Generates stall_inst_miss and stall_data_miss. These feed the pipeline-register write enables: stall_data_miss freezes IF/ID, ID/EX, EX/MEM and MEM/WB; stall_inst_miss freezes the PC and IF/ID.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, memory word width
WORDS, 8, words per cache block (power of two)
MEM_LAT, 4, cycles from mem_rd_en to the matching mem_data_valid; informational, the controller counts returned valids and does not count time

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
imiss  input  1  I-cache miss request; held high until fill_done_i
imiss_addr  input  ADDR_W  I-cache miss byte address
dmiss  input  1  D-cache miss request; held high until fill_done_d
dmiss_addr  input  ADDR_W  D-cache miss byte address
mem_rd_en  output  1  memory read issue, one word per cycle
mem_addr  output  ADDR_W  memory read address
mem_data_valid  input  1  memory returns one word this cycle
mem_data  input  DATA_W  returned word
fill_data  output  DATA_W  word to write into the cache (equals mem_data)
fill_word  output  log2(WORDS)  word index within the block
fill_we_i  output  1  I-cache data-array write enable
fill_we_d  output  1  D-cache data-array write enable
fill_done_i  output  1  one-cycle pulse: I-cache tag/valid write
fill_done_d  output  1  one-cycle pulse: D-cache tag/valid write
stall_inst_miss  output  1  freeze PC and IF/ID
stall_data_miss  output  1  freeze the whole pipeline
busy  output  1  state is not IDLE

Behaviour:
- States: IDLE, FILL_D, FILL_I, DONE_D, DONE_I.
- Registers: 2-bit-plus-flag state, base address, issue counter iss (0..WORDS), receive counter rcv (0..WORDS).
- Reset: state IDLE, iss=rcv=0, base=0. All outputs 0 except stall_* (these are combinational, see below).
- IDLE:
  - dmiss takes priority over imiss, because the D-side instruction is older.
  - On dmiss, go to FILL_D and latch base = dmiss_addr with the low log2(WORDS)+1 bits cleared (0xFFF0 mask at defaults).
  - Otherwise, on imiss, go to FILL_I and latch base from imiss_addr the same way.
  - iss and rcv clear on entry to either FILL state.
- FILL_x, issue side:
  - mem_rd_en = (iss < WORDS).
  - mem_addr = base + 2*iss.
  - iss increments on each issue.
  - Reads go out on consecutive cycles with no gaps.
- FILL_x, receive side:
  - When mem_data_valid is high: fill_we_x = 1, fill_word = rcv[log2(WORDS)-1:0], fill_data = mem_data, and rcv increments. This path is combinational, with zero added latency.
  - When rcv reaches WORDS after an increment, the next state is DONE_x.
- DONE_x: fill_done_x = 1 for exactly one cycle, then the state returns to IDLE. A pending miss from the other side is accepted on the following IDLE cycle.
- In IDLE and DONE_x, mem_data_valid is ignored: no write enable fires and the counters do not change.
- Stalls:
  - stall_data_miss = dmiss | state in {FILL_D, DONE_D}.
  - stall_inst_miss = imiss | state in {FILL_I, DONE_I}.
  - These are combinational, so a stall asserts in the same cycle the miss is raised.
- Latency at defaults: miss raised in cycle 0 gives:
  - FILL in cycle 1
  - reads in cycles 1-8
  - data in cycles 5-12
  - DONE in cycle 13
  - IDLE in cycle 14
  - the cache hits and the miss drops in cycle 14.
- Boundary rules:
  - Simultaneous dmiss and imiss: D is served first and the I stall stays asserted throughout.
  - A miss raised mid-fill is held off until IDLE.
  - A miss that drops mid-fill does not abort the fill; the block always completes.
  - An address of 0xFFFx never wraps the block: base+2*iss stays inside the block, so there is no carry out of the 16-bit address.
  - rst asserted mid-fill forces IDLE on the next edge and abandons the fill with no fill_done. Late mem_data_valid beats that follow are ignored.
  - At most one fill is outstanding at any time.

Test Plan:
1. dmiss=1, dmiss_addr=0x1236 at cycle 0; memory model with 4-cycle latency:
   - mem_rd_en in cycles 1-8 with addresses 0x1230, 0x1232 … 0x123E
   - fill_we_d in cycles 5-12 with fill_word 0..7
   - fill_done_d in cycle 13
   - stall_data_miss high in cycles 0-13, low in cycle 14 after dmiss drops.
2. imiss and dmiss raised together, addresses 0x0040 (imiss) and 0x8008 (dmiss):
   - D fill at base 0x8000 first, with fill_done_d in cycle 13
   - I fill at base 0x0040 starts in cycle 15
   - fill_we_i never fires during the D fill
   - stall_inst_miss stays high through the I DONE cycle.
3. imiss fill in progress, dmiss raised at cycle 3:
   - I fill completes unchanged, with fill_done_i in cycle 13
   - D fill starts in cycle 15
   - stall_data_miss is high from cycle 3 onward.
4. dmiss_addr=0xFFFE: base 0xFFF0, last mem_addr 0xFFFE, no wrap to 0x0000.
5. rst pulsed in cycle 7 of a D fill:
   - next cycle: busy=0, mem_rd_en=0
   - remaining mem_data_valid beats produce no fill_we_* and no fill_done_*.
6. mem_data_valid toggled while in IDLE with no miss pending: all outputs stay 0 and the state stays IDLE.
